// File: rtl/ram_serial_loader.sv
// ram_serial_loader: boot-time loader in front of the system RAM.
// Packs a byte stream (LEN, ADDR, N data words, SUM; each high byte first)
// into 16-bit RAM writes while the CPU is held, then verifies the checksum
// and either hands the RAM port to the CPU (RUN) or parks in ERROR.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  LEN_H    | waiting for word-count high byte
//  LEN_L    | waiting for word-count low byte
//  ADDR_H   | waiting for start-address high byte
//  ADDR_L   | waiting for start-address low byte
//  DATA_H   | waiting for data-word high byte
//  DATA_L   | waiting for data-word low byte (completes a RAM write)
//  SUM_H    | waiting for checksum high byte
//  SUM_L    | waiting for checksum low byte (pass -> RUN, fail -> ERROR)
//  RUN      | terminal: RAM port is a pass-through of the CPU port
//  ERROR    | terminal: checksum mismatch, RAM deselected, CPU held
module ram_serial_loader #(
    parameter bit BYPASS = 1'b0,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [15:0]       cpu_din,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_rnw,
    input  logic              cpu_cs_b,
    output logic [15:0]       ram_din,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_rnw,
    output logic              ram_cs_b,
    output logic              cpu_hold,
    output logic              loaded,
    output logic              error
);

    typedef enum logic [3:0] {
        S_LEN_H,
        S_LEN_L,
        S_ADDR_H,
        S_ADDR_L,
        S_DATA_H,
        S_DATA_L,
        S_SUM_H,
        S_SUM_L,
        S_RUN,
        S_ERROR
    } state_t;

    localparam state_t RESET_STATE = BYPASS ? S_RUN : S_LEN_H;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_hi;
    logic [15:0]         r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_sum;
    logic [15:0]         r_din;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_we;
    logic                r_hold;
    logic                r_loaded;
    logic                r_error;

    logic [15:0]         w_word;
    logic                w_sum_ok;
    logic                w_run;

    // The word being completed is always the held high byte plus the byte on rx_data.
    assign w_word   = {r_hi, rx_data};
    assign w_sum_ok = (w_word == r_sum);
    assign w_run    = (r_state == S_RUN);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: every loading state advances only on a received byte.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN_H:  if (rx_valid) w_next = S_LEN_L;
            S_LEN_L:  if (rx_valid) w_next = S_ADDR_H;
            S_ADDR_H: if (rx_valid) w_next = S_ADDR_L;
            S_ADDR_L: if (rx_valid) w_next = (r_count != 16'd0) ? S_DATA_H : S_SUM_H;
            S_DATA_H: if (rx_valid) w_next = S_DATA_L;
            // A count of 1 here means this word is the last one.
            S_DATA_L: if (rx_valid) w_next = (r_count == 16'd1) ? S_SUM_H : S_DATA_H;
            S_SUM_H:  if (rx_valid) w_next = S_SUM_L;
            S_SUM_L:  if (rx_valid) w_next = w_sum_ok ? S_RUN : S_ERROR;
            S_RUN:    w_next = S_RUN;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = RESET_STATE;
        endcase
    end

    // Byte capture, address/count/checksum bookkeeping and the one-cycle write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi       <= 8'd0;
            r_count    <= 16'd0;
            r_addr     <= '0;
            r_sum      <= 16'd0;
            r_din      <= 16'd0;
            r_ram_addr <= '0;
            r_we       <= 1'b0;
            r_hold     <= ~BYPASS;
            r_loaded   <= BYPASS;
            r_error    <= 1'b0;
        end else begin
            r_we <= rx_valid && (r_state == S_DATA_L);
            if (rx_valid) begin
                case (r_state)
                    S_LEN_H, S_ADDR_H, S_DATA_H, S_SUM_H: begin
                        r_hi <= rx_data;
                    end
                    S_LEN_L: begin
                        r_count <= w_word;
                    end
                    S_ADDR_L: begin
                        // Address bits above ADDR_W are dropped.
                        r_addr <= ADDR_W'(w_word);
                    end
                    S_DATA_L: begin
                        r_din      <= w_word;
                        r_ram_addr <= r_addr;
                        r_sum      <= r_sum + w_word;
                        r_addr     <= r_addr + ADDR_W'(1);
                        r_count    <= r_count - 16'd1;
                    end
                    S_SUM_L: begin
                        if (w_sum_ok) begin
                            r_loaded <= 1'b1;
                            r_hold   <= 1'b0;
                        end else begin
                            r_error  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // RAM port: CPU pass-through in RUN, otherwise the loader's registered write path.
    assign ram_din     = w_run ? cpu_din     : r_din;
    assign ram_address = w_run ? cpu_address : r_ram_addr;
    assign ram_rnw     = w_run ? cpu_rnw     : ~r_we;
    assign ram_cs_b    = w_run ? cpu_cs_b    : ~r_we;

    assign cpu_hold = r_hold;
    assign loaded   = r_loaded;
    assign error    = r_error;

endmodule

// File: tb/tb_ram_serial_loader.sv
// Bench for ram_serial_loader: directed stream cases plus randomized loads,
// each checked against a write list computed from the stream format.
module tb_ram_serial_loader;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [15:0]   cpu_din = 16'h0000;
    logic [AW-1:0] cpu_address = '0;
    logic          cpu_rnw = 1'b1;
    logic          cpu_cs_b = 1'b1;
    logic [15:0]   ram_din;
    logic [AW-1:0] ram_address;
    logic          ram_rnw, ram_cs_b, cpu_hold, loaded, error;

    logic [15:0]   b_cpu_din = 16'h0000;
    logic [AW-1:0] b_cpu_address = '0;
    logic          b_cpu_rnw = 1'b1;
    logic          b_cpu_cs_b = 1'b1;
    logic [15:0]   b_ram_din;
    logic [AW-1:0] b_ram_address;
    logic          b_ram_rnw, b_ram_cs_b, b_cpu_hold, b_loaded, b_error;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_serial_loader #(.BYPASS(1'b0), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cpu_din(cpu_din), .cpu_address(cpu_address), .cpu_rnw(cpu_rnw), .cpu_cs_b(cpu_cs_b),
        .ram_din(ram_din), .ram_address(ram_address), .ram_rnw(ram_rnw), .ram_cs_b(ram_cs_b),
        .cpu_hold(cpu_hold), .loaded(loaded), .error(error)
    );

    ram_serial_loader #(.BYPASS(1'b1), .ADDR_W(AW)) dut_byp (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cpu_din(b_cpu_din), .cpu_address(b_cpu_address), .cpu_rnw(b_cpu_rnw), .cpu_cs_b(b_cpu_cs_b),
        .ram_din(b_ram_din), .ram_address(b_ram_address), .ram_rnw(b_ram_rnw), .ram_cs_b(b_ram_cs_b),
        .cpu_hold(b_cpu_hold), .loaded(b_loaded), .error(b_error)
    );

    // Observed RAM writes during loading: {address, data}, plus back-to-back strobe detection.
    logic [AW+15:0] obs_q[$];
    int             dbl_strobes = 0;
    bit             prev_strobe = 1'b0;

    // Record every loader write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && ram_cs_b == 1'b0 && ram_rnw == 1'b0 && cpu_hold == 1'b1) begin
            obs_q.push_back({ram_address, ram_din});
            if (prev_strobe) dbl_strobes++;
            prev_strobe = 1'b1;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    logic [15:0] wq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = $urandom();
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        obs_q.delete();
        dbl_strobes = 0;
    endtask

    // Stream the words in wq to the loader and compare against the expected write list.
    task automatic load(input string tag, input logic [15:0] start, input int gmin,
                        input int gmax, input bit corrupt);
        logic [15:0] sum;
        logic [15:0] sent_sum;
        logic [15:0] n;
        int          a;
        sum = 16'h0000;
        foreach (wq[i]) sum = sum + wq[i];
        sent_sum = corrupt ? sum + 16'd1 : sum;
        n = 16'(wq.size());
        obs_q.delete();
        dbl_strobes = 0;
        send_byte(n[15:8], $urandom_range(gmax, gmin));
        send_byte(n[7:0], $urandom_range(gmax, gmin));
        send_byte(start[15:8], $urandom_range(gmax, gmin));
        send_byte(start[7:0], $urandom_range(gmax, gmin));
        foreach (wq[i]) begin
            send_byte(wq[i][15:8], $urandom_range(gmax, gmin));
            send_byte(wq[i][7:0], $urandom_range(gmax, gmin));
        end
        send_byte(sent_sum[15:8], $urandom_range(gmax, gmin));
        send_byte(sent_sum[7:0], $urandom_range(gmax, gmin));
        repeat (3) begin @(posedge clk); #1; end
        check({tag, " nwrites"}, obs_q.size(), wq.size());
        foreach (wq[i]) begin
            a = ((int'(start) % (1 << AW)) + i) % (1 << AW);
            if (i < obs_q.size())
                check({tag, " write"}, {12'h0, obs_q[i]}, {12'h0, a[AW-1:0], wq[i]});
        end
        check({tag, " single-cycle strobes"}, dbl_strobes, 0);
        check({tag, " loaded"}, loaded, !corrupt);
        check({tag, " error"}, error, corrupt);
        check({tag, " cpu_hold"}, cpu_hold, corrupt);
    endtask

    initial begin
        int n;
        logic [15:0] st;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state of both instances.
        check("rst cpu_hold", cpu_hold, 1'b1);
        check("rst loaded", loaded, 1'b0);
        check("rst error", error, 1'b0);
        check("rst ram_cs_b", ram_cs_b, 1'b1);
        check("rst ram_rnw", ram_rnw, 1'b1);
        check("byp cpu_hold", b_cpu_hold, 1'b0);
        check("byp loaded", b_loaded, 1'b1);

        // Bypass pass-through is combinational.
        b_cpu_cs_b = 1'b0; b_cpu_rnw = 1'b0; b_cpu_address = 14'h0123; b_cpu_din = 16'hBEEF;
        #1;
        check("byp ram_cs_b", b_ram_cs_b, 1'b0);
        check("byp ram_rnw", b_ram_rnw, 1'b0);
        check("byp ram_address", b_ram_address, 14'h0123);
        check("byp ram_din", b_ram_din, 16'hBEEF);
        b_cpu_cs_b = 1'b1; b_cpu_rnw = 1'b1;

        // Basic two-word load with 3-cycle gaps.
        wq = '{16'h1234, 16'hABCD};
        load("basic", 16'h0010, 3, 3, 1'b0);

        // Pass-through after a good load.
        cpu_cs_b = 1'b0; cpu_rnw = 1'b0; cpu_address = 14'h2A5A; cpu_din = 16'h5AA5;
        #1;
        check("run ram_cs_b", ram_cs_b, 1'b0);
        check("run ram_address", ram_address, 14'h2A5A);
        check("run ram_din", ram_din, 16'h5AA5);
        cpu_rnw = 1'b1;
        #1;
        check("run ram_rnw", ram_rnw, 1'b1);
        cpu_cs_b = 1'b1;

        // Same stream with a bad checksum.
        do_reset();
        load("badsum", 16'h0010, 3, 3, 1'b1);
        cpu_cs_b = 1'b0; cpu_rnw = 1'b0;
        #1;
        check("error ram_cs_b", ram_cs_b, 1'b1);
        send_byte(8'h00, 2);
        check("error sticky", error, 1'b1);
        cpu_cs_b = 1'b1; cpu_rnw = 1'b1;

        // Last address, then a load straddling the wrap.
        do_reset();
        wq = '{16'h55AA};
        load("top", 16'h3FFF, 0, 2, 1'b0);
        do_reset();
        wq = '{16'h0F0F, 16'hF00D};
        load("wrap", 16'h3FFF, 0, 2, 1'b0);

        // Address bits above ADDR_W are ignored.
        do_reset();
        wq = '{16'h1111, 16'h2222, 16'h3333};
        load("hiaddr", 16'hC005, 0, 1, 1'b0);

        // Zero-length load.
        do_reset();
        wq.delete();
        load("nzero", 16'h0000, 0, 3, 1'b0);

        // Reset in the middle of a data word, then a full load.
        do_reset();
        send_byte(8'h00, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
        send_byte(8'h05, 1); send_byte(8'h12, 0);
        reset = 1'b1;
        #1;
        check("midrst ram_cs_b", ram_cs_b, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        check("midrst nwrites", obs_q.size(), 0);
        check("midrst cpu_hold", cpu_hold, 1'b1);
        reset = 1'b0;
        obs_q.delete();
        wq = '{16'h0042, 16'hC0DE};
        load("after_midrst", 16'h0005, 0, 2, 1'b0);

        // Randomized loads.
        for (int k = 0; k < 8; k++) begin
            do_reset();
            wq.delete();
            n = $urandom_range(8, 1);
            for (int j = 0; j < n; j++) wq.push_back(16'($urandom()));
            st = ($urandom_range(3, 0) == 0) ? 16'(16'h3FFC + $urandom_range(3, 0)) : 16'($urandom());
            load("rand", st, 0, 3, ($urandom_range(3, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
